// File: rtl/seq_det_pkg.sv
// Shared defaults for the programmable serial pattern detector.
// Optional toggle counter is built only when SEQ_DET_TOGGLE_CNT_EN is defined.
`ifndef SEQ_DET_PKG_SV
`define SEQ_DET_PKG_SV
package seq_det_pkg;
  localparam int unsigned SEQ_DET_PAT_W = 4;
  localparam int unsigned SEQ_DET_CNT_W = 8;
endpackage
`endif

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial pattern detector with overlap control and match counter.
// Define SEQ_DET_TOGGLE_CNT_EN to add the toggle_count port and its counter.
//
// fill        | meaning
// 0..PAT_W-2  | not enough fresh bits yet, no compare can hit
// PAT_W-1     | next sampled bit completes a full window
// PAT_W       | window full, every sampled bit is a candidate
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = SEQ_DET_PAT_W,
  parameter int unsigned CNT_W = SEQ_DET_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             z,
`ifdef SEQ_DET_TOGGLE_CNT_EN
  output logic [CNT_W-1:0] toggle_count,
`endif
  output logic [CNT_W-1:0] match_count
);
  localparam int unsigned FW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] cand;
  logic [FW-1:0]    fill;
  logic             hit;

  assign cand = {hist[PAT_W-2:0], x};
  assign hit  = en && (cand == pattern) && (fill >= FW'(PAT_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else begin
      z <= hit;
      if (en) begin
        hist <= cand;
        // A non-overlapping hit consumes the window, so the next match needs all fresh bits.
        if (hit && !overlap) begin
          fill <= '0;
        end else if (fill != FW'(PAT_W)) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (clr_cnt),
    .count (match_count)
  );

`ifdef SEQ_DET_TOGGLE_CNT_EN
  logic prev_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_x <= 1'b0;
    end else if (en) begin
      prev_x <= x;
    end
  end

  sat_counter #(.W(CNT_W)) u_toggle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (en && (x != prev_x)),
    .clr   (clr_cnt),
    .count (toggle_count)
  );
`endif
endmodule

// File: tb/tb_param_seq_detector.sv
// Randomised and directed bench for param_seq_detector against a stream-level reference model.
module tb_param_seq_detector;
  localparam int PW  = 4;
  localparam int CW  = 8;
  localparam int CW2 = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          x = 1'b0;
  logic          overlap = 1'b1;
  logic          clr_cnt = 1'b0;
  logic [PW-1:0] pattern = 4'b1011;
  logic          z, z2;
  logic [CW-1:0]  mc;
  logic [CW2-1:0] mc2;
`ifdef SEQ_DET_TOGGLE_CNT_EN
  logic [CW-1:0]  tc;
  logic [CW2-1:0] tc2;
`endif

  param_seq_detector #(.PAT_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .pattern(pattern), .overlap(overlap),
    .clr_cnt(clr_cnt), .z(z),
`ifdef SEQ_DET_TOGGLE_CNT_EN
    .toggle_count(tc),
`endif
    .match_count(mc)
  );

  param_seq_detector #(.PAT_W(PW), .CNT_W(CW2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .x(x), .pattern(pattern), .overlap(overlap),
    .clr_cnt(clr_cnt), .z(z2),
`ifdef SEQ_DET_TOGGLE_CNT_EN
    .toggle_count(tc2),
`endif
    .match_count(mc2)
  );

  always #5 clk = ~clk;

  // Reference model: the sampled stream, how many of its newest bits are fresh, raw event totals.
  bit q[$];
  int fresh;
  int m_raw;
  int t_raw;
  bit m_prev;
  bit m_z;

  int compared = 0;
  int mismatched = 0;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    fresh = 0;
    m_raw = 0;
    t_raw = 0;
    m_prev = 1'b0;
    m_z = 1'b0;
  endtask

  task automatic check_all();
    chk("z", {31'd0, z}, {31'd0, m_z});
    chk("z_sat", {31'd0, z2}, {31'd0, m_z});
    chk("match_count", 32'(mc), 32'(sat(m_raw, CW)));
    chk("match_count_sat", 32'(mc2), 32'(sat(m_raw, CW2)));
`ifdef SEQ_DET_TOGGLE_CNT_EN
    chk("toggle_count", 32'(tc), 32'(sat(t_raw, CW)));
    chk("toggle_count_sat", 32'(tc2), 32'(sat(t_raw, CW2)));
`endif
  endtask

  task automatic step(input bit e, input bit b, input bit clr);
    bit hit;
    en = e;
    x = b;
    clr_cnt = clr;
    @(posedge clk);
    hit = 1'b0;
    if (e) begin
      q.push_back(b);
      if (q.size() > PW) void'(q.pop_front());
      fresh++;
      if (fresh >= PW) begin
        hit = 1'b1;
        for (int i = 0; i < PW; i++)
          if (q[i] != pattern[PW-1-i]) hit = 1'b0;
      end
      if (hit && !overlap) fresh = 0;
      if (b != m_prev) t_raw++;
      m_prev = b;
    end
    m_z = hit;
    if (clr) begin
      m_raw = 0;
      t_raw = 0;
    end else if (hit) begin
      m_raw++;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    clr_cnt = 1'b0;
    model_reset();
    #1;
    chk("reset_z", {31'd0, z}, 32'd0);
    chk("reset_match_count", 32'(mc), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_bits(input bit [15:0] bits, input int n, output bit [15:0] zv);
    zv = '0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], 1'b0);
      zv[i] = z;
    end
  endtask

  initial begin
    bit [15:0] zv;
    bit [15:0] s;
    model_reset();
    do_reset();

    // 1: overlapping 1011 in 1011011
    pattern = 4'b1011;
    overlap = 1'b1;
    s = 16'b1011011;
    run_bits(s, 7, zv);
    chk("t1_z_positions", 32'(zv), 32'b1001000);
    chk("t1_match_count", 32'(mc), 32'd2);

    // 2: same stream, non-overlapping
    do_reset();
    overlap = 1'b0;
    run_bits(s, 7, zv);
    chk("t2_z_positions", 32'(zv), 32'b0001000);
    chk("t2_match_count", 32'(mc), 32'd1);

    // 3: reset mid-stream discards partial pattern
    do_reset();
    overlap = 1'b1;
    s = 16'b101;
    run_bits(s, 3, zv);
    #2 rst = 1'b0;
    model_reset();
    #1 chk("t3_async_z", {31'd0, z}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    s = 16'b11011;
    run_bits(s, 5, zv);
    chk("t3_z_positions", 32'(zv), 32'b10000);

    // 4: enable gap between bits 2 and 3
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      chk("t4_gap_z", {31'd0, z}, 32'd0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("t4_z_before_last", {31'd0, z}, 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("t4_z_after_last", {31'd0, z}, 32'd1);

    // 5: saturation at CNT_W=2, then clear alongside a hit
    do_reset();
    pattern = 4'b1111;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    chk("t5_match_count_sat", 32'(mc2), 32'd3);
    chk("t5_match_count_wide", 32'(mc), 32'd5);
    step(1'b1, 1'b1, 1'b1);
    chk("t5_clr_z", {31'd0, z}, 32'd1);
    chk("t5_clr_count", 32'(mc), 32'd0);

`ifdef SEQ_DET_TOGGLE_CNT_EN
    // 6: toggles in 0,1,1,0,1
    do_reset();
    s = 16'b01101;
    run_bits(s, 5, zv);
    chk("t6_toggle_count", 32'(tc), 32'd3);
`endif

    // Random traffic with pattern/overlap changes, clears and resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) pattern = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) overlap = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 999) < 5) do_reset();
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 2));
      if ((n % 500) == 0) pattern = ($urandom_range(0, 1) != 0) ? 4'b1111 : 4'b0000;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
